// File: rtl/score_display_seq_pkg.sv
// Shared types and constants for the score display: colours, segment indices,
// digit glyph table and converter FSM state.
package score_disp_pkg;

  localparam logic [5:0] COL_RED    = 6'b110000;
  localparam logic [5:0] COL_GREEN  = 6'b001100;
  localparam logic [5:0] COL_BLUE   = 6'b000011;
  localparam logic [5:0] COL_YELLOW = 6'b111100;
  localparam logic [5:0] COL_ORANGE = 6'b110100;
  localparam logic [5:0] COL_WHITE  = 6'b111111;
  localparam logic [5:0] COL_BLACK  = 6'b000000;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_idx_e;

  // Bit n lights segment n of seg_idx_e (bit 6 = g ... bit 0 = a).
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111   // 9
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_lookup(input logic [3:0] d);
    if (d > 4'd9) return 7'b0000000;
    return SEG_TABLE[d];
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/score_display_seq_if.sv
// Pixel-timing bundle from the VGA timing generator.
interface score_display_seq_if;
  logic [9:0] col;
  logic [9:0] row;
  logic       valid;
  logic       frame_start;

  modport master (output col, row, valid, frame_start);
  modport slave  (input  col, row, valid, frame_start);
endinterface

// File: rtl/score_display_seq_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter with saturation to the
// largest NUM_DIGITS-digit decimal value.
module bin2bcd_seq
  import score_disp_pkg::*;
#(
  parameter int unsigned SCORE_W    = 17,
  parameter int unsigned NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int unsigned     BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned     CNT_W = $clog2(SCORE_W + 1);
  localparam longint unsigned MAXV  = pow10(NUM_DIGITS) - 1;

  conv_state_e                state_q, state_d;
  logic [SCORE_W-1:0]         bin_q, bin_d;
  logic [BCD_W-1:0]           bcd_q, bcd_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [SCORE_W-1:0]         bin_sat;
  logic [BCD_W-1:0]           bcd_adj;
  logic [BCD_W+SCORE_W-1:0]   shifted;

  assign bin_sat = (64'(bin) > MAXV) ? SCORE_W'(MAXV) : bin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SHIFT;
      ST_SHIFT:  if (cnt_q == CNT_W'(1)) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values and status decode.
  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_COMMIT);
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d = bin_sat;
          bcd_d = '0;
          cnt_d = CNT_W'(SCORE_W);
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = shifted;
        cnt_d          = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/score_display_seq.sv
// Seven-segment score renderer: converts the score once per frame into a
// double-buffered digit register and draws it. Option: LEADING_ZERO_BLANK_EN.
module score_display_seq
  import score_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 5,
  parameter int unsigned SCORE_W     = 17,
  parameter int          X0          = 20,
  parameter int          Y0          = 70,
  parameter int          DIGIT_W     = 25,
  parameter int          DIGIT_PITCH = 26,
  parameter int          DIGIT_H     = 40,
  parameter int          THICK       = 5,
  parameter logic [5:0]  FG          = COL_GREEN,
  parameter logic [5:0]  BG          = COL_BLACK
) (
  input  logic                clk,
  input  logic                reset,
  score_display_seq_if.slave  vga,
  input  logic [SCORE_W-1:0]  score,
  output logic [5:0]          digit_rgb,
  output logic                busy
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int          MID   = DIGIT_H / 2;
  localparam int          G_TOP = MID - THICK / 2;

  logic                  conv_done;
  logic [BCD_W-1:0]      conv_bcd;
  logic [BCD_W-1:0]      disp_q;
  logic [NUM_DIGITS-1:0] blank_c;
  logic                  lit_c;
  logic [5:0]            rgb_q;
  int                    px_dx, px_dy;
  logic [3:0]            dig_v;
  logic [6:0]            segs_v;

  bin2bcd_seq #(
    .SCORE_W   (SCORE_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_conv (
    .clk  (clk),
    .reset(reset),
    .start(vga.frame_start),
    .bin  (score),
    .busy (busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  // Display buffer only changes on a completed conversion, never mid-shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          disp_q <= '0;
    else if (conv_done) disp_q <= conv_bcd;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead_c;
  always_comb begin
    lead_c  = 1'b1;
    blank_c = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      lead_c     = lead_c && (disp_q[4*(int'(NUM_DIGITS)-1-k) +: 4] == 4'd0);
      blank_c[k] = lead_c && (k != int'(NUM_DIGITS) - 1);
    end
  end
`else
  assign blank_c = '0;
`endif

  // Region decode: which digit box the pixel is in, and whether it hits a lit segment.
  always_comb begin
    lit_c  = 1'b0;
    px_dx  = 0;
    dig_v  = 4'd0;
    segs_v = 7'b0000000;
    px_dy  = int'(vga.row) - Y0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      px_dx  = int'(vga.col) - (X0 + k * DIGIT_PITCH);
      dig_v  = disp_q[4*(int'(NUM_DIGITS)-1-k) +: 4];
      segs_v = seg_lookup(dig_v);
      if (px_dx >= 0 && px_dx < DIGIT_W && px_dy >= 0 && px_dy < DIGIT_H && !blank_c[k]) begin
        if ((segs_v[SEG_A] && px_dy < THICK) ||
            (segs_v[SEG_D] && px_dy >= DIGIT_H - THICK) ||
            (segs_v[SEG_G] && px_dy >= G_TOP && px_dy < G_TOP + THICK) ||
            (segs_v[SEG_F] && px_dx < THICK && px_dy < MID) ||
            (segs_v[SEG_B] && px_dx >= DIGIT_W - THICK && px_dy < MID) ||
            (segs_v[SEG_E] && px_dx < THICK && px_dy >= MID) ||
            (segs_v[SEG_C] && px_dx >= DIGIT_W - THICK && px_dy >= MID))
          lit_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_q <= BG;
    else       rgb_q <= (lit_c && vga.valid) ? FG : BG;
  end

  assign digit_rgb = rgb_q;

endmodule

// File: tb/tb_score_display_seq.sv
// Randomized self-checking bench for score_display_seq against a digit/glyph
// reference model built from decimal arithmetic and segment-letter strings.
module tb_score_display_seq;

  localparam int     N    = 5;
  localparam int     SW   = 17;
  localparam int     X0   = 20;
  localparam int     Y0   = 70;
  localparam int     W    = 25;
  localparam int     P    = 26;
  localparam int     H    = 40;
  localparam int     T    = 5;
  localparam int     M    = H / 2;
  localparam int     FG   = 6'b001100;
  localparam int     BG   = 6'b000000;
  localparam longint MAXV = 99999;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] score;
  logic [5:0]    digit_rgb;
  logic          busy;

  score_display_seq_if vif();

  score_display_seq dut (
    .clk      (clk),
    .reset    (reset),
    .vga      (vif),
    .score    (score),
    .digit_rgb(digit_rgb),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int     checks   = 0;
  int     failures = 0;
  longint disp_model;

  string SEG_STR [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                          "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
  int CDX [7] = '{12, 22, 22, 12, 2, 2, 12};  // a b c d e f g centres
  int CDY [7] = '{2, 10, 30, 37, 30, 10, 20};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint p10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic bit has_seg(input string s, input string ch);
    for (int i = 0; i < s.len(); i++)
      if (s.substr(i, i) == ch) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_pix(input longint val, input int c, input int r, input bit v);
    int    dx, dy, d;
    bit    lit;
    string s;
    if (!v) return BG;
    dy = r - Y0;
    for (int k = 0; k < N; k++) begin
      dx = c - (X0 + k * P);
      if (dx >= 0 && dx < W && dy >= 0 && dy < H) begin
        d = int'((val / p10(N - 1 - k)) % 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (k < N - 1 && val < p10(N - 1 - k)) return BG;
`endif
        s   = SEG_STR[d];
        lit = (has_seg(s, "a") && dy < T) ||
              (has_seg(s, "d") && dy >= H - T) ||
              (has_seg(s, "g") && dy >= M - T / 2 && dy < M - T / 2 + T) ||
              (has_seg(s, "f") && dx < T && dy < M) ||
              (has_seg(s, "b") && dx >= W - T && dy < M) ||
              (has_seg(s, "e") && dx < T && dy >= M) ||
              (has_seg(s, "c") && dx >= W - T && dy >= M);
        return lit ? FG : BG;
      end
    end
    return BG;
  endfunction

  task automatic drive_pix(input int c, input int r, input bit v);
    vif.col   = 10'(c);
    vif.row   = 10'(r);
    vif.valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pix_check(input string tag, input int c, input int r, input bit v);
    drive_pix(c, r, v);
    check(tag, 64'(digit_rgb), 64'(model_pix(disp_model, c, r, v)));
  endtask

  task automatic pix_const(input string tag, input int c, input int r, input bit v, input int exp);
    drive_pix(c, r, v);
    check(tag, 64'(digit_rgb), 64'(exp));
  endtask

  task automatic sweep(input string tag);
    for (int k = 0; k < N; k++)
      for (int s = 0; s < 7; s++)
        pix_check(tag, X0 + k * P + CDX[s], Y0 + CDY[s], 1'b1);
  endtask

  // Pulse frame_start with score s; optionally pulse again at busy cycle second_at.
  task automatic convert(input longint s, input int second_at, input longint s2, output int busy_cycles);
    int cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    score           = SW'(s);
    vif.frame_start = 1'b1;
    @(posedge clk);
    #1;
    vif.frame_start = 1'b0;
    score           = SW'($urandom);
    cnt             = 0;
    while (busy && cnt < 100) begin
      if (cnt == second_at) begin
        score           = SW'(s2);
        vif.frame_start = 1'b1;
      end else begin
        vif.frame_start = 1'b0;
      end
      cnt++;
      @(posedge clk);
      #1;
    end
    vif.frame_start = 1'b0;
    busy_cycles     = cnt;
    disp_model      = (s > MAXV) ? MAXV : s;
  endtask

  task automatic conv_sweep(input longint s, input string tag);
    int bc;
    convert(s, -1, 0, bc);
    check({tag, "_busy"}, 64'(bc), 64'(18));
    sweep(tag);
  endtask

  initial begin
    int     bc;
    int     extra;
    longint sat_vals [3] = '{100000, 99999, 131071};

    reset           = 1'b1;
    score           = '0;
    vif.col         = '0;
    vif.row         = '0;
    vif.valid       = 1'b0;
    vif.frame_start = 1'b0;
    disp_model      = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", 64'(digit_rgb), 64'(BG));
    check("reset_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    sweep("reset_buf");

    convert(12345, -1, 0, bc);
    check("busy_len_12345", 64'(bc), 64'(18));
    pix_const("msd1_a_dark", X0 + T / 2, Y0 + T / 2, 1'b1, BG);
    pix_const("msd1_b_lit", X0 + W - 1, Y0 + 1, 1'b1, FG);
    sweep("d12345");

    for (int d = 0; d < 10; d++) begin
      conv_sweep(d, $sformatf("lsd%0d", d));
      if (d == 0) pix_const("g_of_0", X0 + 4 * P + 12, Y0 + M, 1'b1, BG);
      if (d == 8) pix_const("g_of_8", X0 + 4 * P + 12, Y0 + M, 1'b1, FG);
    end

    for (int i = 0; i < 3; i++) begin
      conv_sweep(sat_vals[i], $sformatf("sat%0d", i));
      pix_const("sat_msd_g", X0 + 12, Y0 + M, 1'b1, FG);
    end

    // Gap column and valid masking while 99999 is displayed.
    pix_const("gap_col", X0 + 25, Y0 + 2, 1'b1, BG);
    pix_check("gap_col_m", X0 + 25, Y0 + 10, 1'b1);
    pix_const("lit_valid", X0 + 22, Y0 + 10, 1'b1, FG);
    pix_const("valid_low", X0 + 22, Y0 + 10, 1'b0, BG);

    convert(24680, 5, 13579, bc);
    check("dbl_busy_len", 64'(bc), 64'(18));
    extra = 0;
    repeat (25) begin
      if (busy) extra++;
      @(posedge clk);
      #1;
    end
    check("dbl_no_retrigger", 64'(extra), 64'(0));
    sweep("dbl_first");

    // Reset in the middle of converting 54321, with a lit pixel on screen.
    convert(99999, -1, 0, bc);
    drive_pix(X0 + 22, Y0 + 10, 1'b1);
    score           = SW'(54321);
    vif.frame_start = 1'b1;
    @(posedge clk);
    #1;
    vif.frame_start = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_lit", 64'(digit_rgb), 64'(FG));
    check("pre_reset_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check("async_rgb", 64'(digit_rgb), 64'(BG));
    check("async_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    disp_model = 0;
    extra      = 0;
    repeat (30) begin
      if (busy) extra++;
      @(posedge clk);
      #1;
    end
    check("no_commit_after_reset", 64'(extra), 64'(0));
    sweep("post_reset");

    conv_sweep(42, "v42");
    conv_sweep(0, "v0");

    for (int r = 0; r < 6; r++) begin
      convert(longint'($urandom_range(0, 131071)), -1, 0, bc);
      check("rnd_busy", 64'(bc), 64'(18));
      for (int i = 0; i < 40; i++)
        pix_check("rnd_pix", int'($urandom_range(0, 160)), int'($urandom_range(60, 120)),
                  ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
